// File: rtl/elevator_ctrl.sv
// SCAN-policy car controller: latches floor calls, steps the car one floor per MOVE_TIME cycles,
// and hands off to the door timer. Optional `ELEV_STOP_EN adds a `stop` input that freezes motion.
module elevator_ctrl #(
    parameter int unsigned FLOORS    = 4,
    parameter int unsigned FLOOR_W   = 2,
    parameter int unsigned MOVE_TIME = 4,
    parameter int unsigned MOVE_W    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FLOORS-1:0]  req,
    input  logic               door_close,
`ifdef ELEV_STOP_EN
    input  logic               stop,
`endif
    output logic               door_open,
    output logic [FLOOR_W-1:0] floor,
    output logic               up,
    output logic               down,
    output logic [FLOORS-1:0]  pending,
    output logic               busy
);

    typedef enum logic [1:0] {StIdle, StMove, StDoor} state_e;

    state_e              state;
    logic                dir;  // 1 = up
    logic [MOVE_W-1:0]   cnt;
    logic                close_q;
    logic                halt;

    logic                step;
    logic [FLOOR_W-1:0]  nxt_floor;
    logic [FLOOR_W-1:0]  eval_floor;
    logic                any_above;
    logic                any_below;
    logic                here;
    logic                ahead;
    logic                behind;
    logic                rise;
    logic                go_door;
    logic [FLOORS-1:0]   set_mask;
    logic [FLOORS-1:0]   clr_mask;

`ifdef ELEV_STOP_EN
    assign halt = stop;
`else
    assign halt = 1'b0;
`endif

    // Decisions on an arrival edge are made against the floor the car is stepping onto.
    always_comb begin
        step       = (state == StMove) && !halt && (cnt == MOVE_W'(MOVE_TIME - 1));
        nxt_floor  = dir ? floor + FLOOR_W'(1) : floor - FLOOR_W'(1);
        eval_floor = step ? nxt_floor : floor;
        any_above  = 1'b0;
        any_below  = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (pending[i] && (i > int'(eval_floor))) any_above = 1'b1;
            if (pending[i] && (i < int'(eval_floor))) any_below = 1'b1;
        end
        here     = pending[eval_floor];
        ahead    = dir ? any_above : any_below;
        behind   = dir ? any_below : any_above;
        rise     = door_close && !close_q;
        go_door  = ((state == StIdle) && !halt && here) || (step && here);
        clr_mask = '0;
        if (go_door) clr_mask[eval_floor] = 1'b1;
        set_mask = req;
        if (state == StDoor) set_mask[floor] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            floor     <= '0;
            pending   <= '0;
            door_open <= 1'b0;
            up        <= 1'b0;
            down      <= 1'b0;
            busy      <= 1'b0;
            cnt       <= '0;
            dir       <= 1'b1;
            close_q   <= 1'b0;
        end else begin
            close_q   <= door_close;
            pending   <= (pending | set_mask) & ~clr_mask;
            door_open <= go_door;
            unique case (state)
                StIdle: begin
                    if (!halt) begin
                        if (here) begin
                            state <= StDoor;
                            busy  <= 1'b1;
                        end else if (any_above) begin
                            state <= StMove;
                            dir   <= 1'b1;
                            up    <= 1'b1;
                            busy  <= 1'b1;
                            cnt   <= '0;
                        end else if (any_below) begin
                            state <= StMove;
                            dir   <= 1'b0;
                            down  <= 1'b1;
                            busy  <= 1'b1;
                            cnt   <= '0;
                        end
                    end
                end
                StMove: begin
                    if (halt) begin
                        up   <= 1'b0;
                        down <= 1'b0;
                    end else if (step) begin
                        floor <= nxt_floor;
                        cnt   <= '0;
                        if (here) begin
                            state <= StDoor;
                            up    <= 1'b0;
                            down  <= 1'b0;
                        end else if (ahead) begin
                            up   <= dir;
                            down <= !dir;
                        end else if (behind) begin
                            dir  <= !dir;
                            up   <= !dir;
                            down <= dir;
                        end else begin
                            state <= StIdle;
                            up    <= 1'b0;
                            down  <= 1'b0;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt  <= cnt + MOVE_W'(1);
                        up   <= dir;
                        down <= !dir;
                    end
                end
                StDoor: begin
                    if (rise) begin
                        if (ahead) begin
                            state <= StMove;
                            cnt   <= '0;
                            up    <= dir && !halt;
                            down  <= !dir && !halt;
                        end else if (behind) begin
                            state <= StMove;
                            cnt   <= '0;
                            dir   <= !dir;
                            up    <= !dir && !halt;
                            down  <= dir && !halt;
                        end else begin
                            state <= StIdle;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_ctrl.sv
// Scoreboard bench for elevator_ctrl: stimulus pushes expected door events, a monitor checks them.
module tb_elevator_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic       door_close = 1'b0;
    logic       stop = 1'b0;
    logic       door_open;
    logic [1:0] floor;
    logic       up;
    logic       down;
    logic [3:0] pending;
    logic       busy;

    elevator_ctrl #(
        .FLOORS    (4),
        .FLOOR_W   (2),
        .MOVE_TIME (4),
        .MOVE_W    (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .door_close (door_close),
`ifdef ELEV_STOP_EN
        .stop       (stop),
`endif
        .door_open  (door_open),
        .floor      (floor),
        .up         (up),
        .down       (down),
        .pending    (pending),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int fl;
        int pend;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   dc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input int fl, input int pend);
        exp_t e;
        e.cyc  = c;
        e.fl   = fl;
        e.pend = pend;
        exp_q.push_back(e);
    endtask

    // Door timer model: close is a one-cycle pulse sampled 5 edges after the open edge.
    always @(negedge clk) begin
        door_close = 1'b0;
        if (dc > 0) begin
            dc--;
            if (dc == 0) door_close = 1'b1;
        end
        if (rst_n && door_open) dc = 4;
    end

    // Monitor: every door_open cycle must match the next expected arrival.
    always @(negedge clk) begin
        if (rst_n && door_open) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL door_unexpected: got door_open at cycle %0d floor %0d expected none",
                         cyc, floor);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("door_cycle", 32'(cyc), 32'(e.cyc));
                check("door_floor", 32'(floor), 32'(e.fl));
                check("door_pending", 32'(pending), 32'(e.pend));
            end
        end
    end

    // Drive req for exactly one sampling edge; n is that edge's index.
    task automatic issue(input logic [3:0] v, output int n);
        req = v;
        @(posedge clk);
        #1;
        n   = cyc;
        req = '0;
    endtask

    task automatic wait_until(input int target);
        int i;
        for (i = 0; i < 300 && cyc != target; i++) @(negedge clk);
        if (cyc != target) begin
            checks++;
            errors++;
            $display("FAIL wait_until: got cycle %0d expected %0d", cyc, target);
        end
    endtask

    task automatic wait_idle();
        int i;
        repeat (2) @(negedge clk);
        for (i = 0; i < 200 && (busy || exp_q.size() != 0); i++) @(negedge clk);
        if (busy || exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got busy=%0b queued=%0d expected idle", busy, exp_q.size());
        end
    endtask

    initial begin
        int n;
        int m;
        int cnt_up;
        int motion;

        // Reset with all calls pressed: nothing may latch.
        req = 4'b1111;
        repeat (2) begin
            @(negedge clk);
            check("reset_outputs", 32'({door_open, up, down, busy, floor, pending}), 32'd0);
        end
        rst_n = 1'b1;
        req   = '0;

        // Same floor call at floor 0.
        issue(4'b0001, n);
        push(n + 1, 0, 0);
        motion = 0;
        for (int i = 1; i <= 6; i++) begin
            wait_until(n + i);
            motion += int'(up | down);
        end
        check("same_floor_no_motion", 32'(motion), 32'd0);
        wait_idle();
        check("same_floor_floor", 32'(floor), 32'd0);

        // Single trip 0 -> 3.
        issue(4'b1000, n);
        push(n + 13, 3, 0);
        cnt_up = 0;
        for (int i = 1; i <= 13; i++) begin
            wait_until(n + i);
            cnt_up += int'(up);
            if (i == 5 || i == 9 || i == 13) check("trip_floor", 32'(floor), 32'((i - 1) / 4));
        end
        check("trip_up_cycles", 32'(cnt_up), 32'd12);
        wait_idle();
        check("trip_idle_floor", 32'(floor), 32'd3);

        // Move down to floor 1 to set up the SCAN case.
        issue(4'b0010, n);
        push(n + 9, 1, 0);
        wait_until(n + 2);
        check("down_dir", 32'({up, down}), 32'b01);
        wait_idle();

        // SCAN from floor 1 with calls at 0 and 3: up first, then reverse.
        issue(4'b1001, m);
        push(m + 9, 3, 4'b0001);
        push(m + 26, 0, 4'b0000);
        wait_until(m + 1);
        check("scan_pending", 32'(pending), 32'b1001);
        check("scan_up_first", 32'({up, down}), 32'b10);
        wait_until(m + 14);
        check("scan_reverse", 32'({up, down}), 32'b01);
        wait_idle();
        check("scan_end_floor", 32'(floor), 32'd0);

        // Mid-travel call for floor 2 while moving 0 -> 3.
        issue(4'b1000, n);
        push(n + 9, 2, 4'b1000);
        push(n + 18, 3, 0);
        wait_until(n + 6);
        issue(4'b0100, m);
        check("mid_call_edge", 32'(m), 32'(n + 7));
        check("mid_call_pending", 32'(pending), 32'b1100);
        wait_until(n + 14);
        check("mid_continue_up", 32'({up, down}), 32'b10);
        wait_idle();

`ifdef ELEV_STOP_EN
        // Six stopped cycles mid-segment delay arrival by exactly six cycles.
        issue(4'b0100, n);
        push(n + 11, 2, 0);
        wait_until(n + 2);
        stop = 1'b1;
        wait_until(n + 5);
        check("stop_frozen", 32'({floor, up, down}), 32'b1100);
        wait_until(n + 8);
        stop = 1'b0;
        wait_until(n + 9);
        check("stop_resume", 32'({up, down}), 32'b01);
        wait_idle();
`endif

        // Asynchronous reset in the middle of a move.
        issue(4'b0001, n);
        wait_until(n + 3);
        check("pre_reset_moving", 32'(down), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset", 32'({door_open, up, down, busy, floor, pending}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_idle", 32'({busy, floor, pending}), 32'd0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
